// File: rtl/mux5_rr_arbiter_if.sv
// Bundle of the five-channel request/data inputs and the registered output of mux5_rr_arbiter.
// The lock signal exists only when MUX5_ARB_LOCK_EN is defined.
interface mux5_rr_arbiter_if #(
    parameter int word_size = 8
);
    logic [4:0]           req;
    logic [word_size-1:0] data_a;
    logic [word_size-1:0] data_b;
    logic [word_size-1:0] data_c;
    logic [word_size-1:0] data_d;
    logic [word_size-1:0] data_e;
    logic                 out_ready;
`ifdef MUX5_ARB_LOCK_EN
    logic                 lock;
`endif
    logic [4:0]           gnt;
    logic [word_size-1:0] out_data;
    logic                 out_valid;
    logic [2:0]           out_sel;

`ifdef MUX5_ARB_LOCK_EN
    modport master (
        output req, data_a, data_b, data_c, data_d, data_e, out_ready, lock,
        input  gnt, out_data, out_valid, out_sel
    );
    modport slave (
        input  req, data_a, data_b, data_c, data_d, data_e, out_ready, lock,
        output gnt, out_data, out_valid, out_sel
    );
`else
    modport master (
        output req, data_a, data_b, data_c, data_d, data_e, out_ready,
        input  gnt, out_data, out_valid, out_sel
    );
    modport slave (
        input  req, data_a, data_b, data_c, data_d, data_e, out_ready,
        output gnt, out_data, out_valid, out_sel
    );
`endif
endinterface

// File: rtl/mux5_rr_arbiter.sv
// Five-channel round-robin arbiter feeding a one-entry output register.
// Defining MUX5_ARB_LOCK_EN adds the lock input that re-grants the previous winner.
module mux5_rr_arbiter #(
    parameter int word_size = 8
) (
    input  logic               clk,
    input  logic               rst,
    mux5_rr_arbiter_if.slave   bus
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t               state_reg, state_next;
    logic [2:0]           last_reg;
    logic [2:0]           out_sel_reg;
    logic [word_size-1:0] out_data_reg;

    logic [word_size-1:0] data_arr [5];
    logic [2:0]           cand [5];
    logic [4:0]           cand_hit;
    logic [2:0]           winner;
    logic                 load_slot;
    logic                 any_req;
    logic                 take;
    logic [4:0]           gnt;

    assign data_arr[0] = bus.data_a;
    assign data_arr[1] = bus.data_b;
    assign data_arr[2] = bus.data_c;
    assign data_arr[3] = bus.data_d;
    assign data_arr[4] = bus.data_e;

    // cand[gi] is the channel searched in position gi, starting just after last.
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_cand
            logic [3:0] sum;
            assign sum          = {1'b0, last_reg} + 4'(gi + 1);
            assign cand[gi]     = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
            assign cand_hit[gi] = bus.req[cand[gi]];
        end
    endgenerate

    always_comb begin
        winner = last_reg;
        for (int i = 4; i >= 0; i--) begin
            if (cand_hit[i]) begin
                winner = cand[i];
            end
        end
`ifdef MUX5_ARB_LOCK_EN
        if (bus.lock && bus.req[last_reg]) begin
            winner = last_reg;
        end
`endif
    end

    assign any_req   = |bus.req;
    assign load_slot = (state_reg == EMPTY) || bus.out_ready;

    always_comb begin
        state_next = state_reg;
        take       = 1'b0;
        gnt        = 5'b00000;
        if (load_slot) begin
            if (any_req) begin
                state_next = FULL;
                take       = 1'b1;
                gnt        = 5'b00001 << winner;
            end else begin
                state_next = EMPTY;
            end
        end
        // Grant is suppressed while reset is held so no source drops a word.
        if (rst) begin
            gnt  = 5'b00000;
            take = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= EMPTY;
            last_reg     <= 3'd4;
            out_sel_reg  <= 3'd0;
            out_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (take) begin
                last_reg     <= winner;
                out_sel_reg  <= winner;
                out_data_reg <= data_arr[winner];
            end
        end
    end

    assign bus.gnt       = gnt;
    assign bus.out_data  = out_data_reg;
    assign bus.out_sel   = out_sel_reg;
    assign bus.out_valid = (state_reg == FULL);
endmodule

// File: tb/tb_mux5_rr_arbiter.sv
// Directed self-checking bench for mux5_rr_arbiter; grants checked mid-cycle,
// registered outputs checked just after the rising edge.
module tb_mux5_rr_arbiter;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    mux5_rr_arbiter_if #(.word_size(8)) bus ();

    mux5_rr_arbiter #(.word_size(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] dv [5];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic to_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic to_mid();
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        dv[0] = 8'h11; dv[1] = 8'h22; dv[2] = 8'h33; dv[3] = 8'h44; dv[4] = 8'h55;
        bus.data_a = dv[0]; bus.data_b = dv[1]; bus.data_c = dv[2];
        bus.data_d = dv[3]; bus.data_e = dv[4];
        bus.req = 5'b11111;
        bus.out_ready = 1'b1;
`ifdef MUX5_ARB_LOCK_EN
        bus.lock = 1'b0;
`endif
        rst = 1'b1;

        // Reset with every channel requesting
        to_edge();
        to_edge();
        check("rst_gnt", 32'(bus.gnt), 32'h0);
        check("rst_valid", 32'(bus.out_valid), 32'h0);
        check("rst_sel", 32'(bus.out_sel), 32'h0);
        check("rst_data", 32'(bus.out_data), 32'h0);

        // All-request rotation starting from channel 0 right after release
        to_mid();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("all_gnt%0d", i), 32'(bus.gnt), 32'(5'b00001 << (i % 5)));
            to_edge();
            check($sformatf("all_sel%0d", i), 32'(bus.out_sel), 32'(i % 5));
            check($sformatf("all_data%0d", i), 32'(bus.out_data), 32'(dv[i % 5]));
            check($sformatf("all_valid%0d", i), 32'(bus.out_valid), 32'h1);
            to_mid();
        end

        // Single requester is granted on every load slot
        bus.req = 5'b01000;
        bus.data_d = 8'hA5;
        for (int i = 0; i < 2; i++) begin
            #1;
            check($sformatf("single_gnt%0d", i), 32'(bus.gnt), 32'h08);
            to_edge();
            check($sformatf("single_data%0d", i), 32'(bus.out_data), 32'hA5);
            check($sformatf("single_sel%0d", i), 32'(bus.out_sel), 32'h3);
            check($sformatf("single_valid%0d", i), 32'(bus.out_valid), 32'h1);
            to_mid();
        end

        // No request in a load slot: register empties, data and sel hold
        bus.req = 5'b00000;
        #1;
        check("idle_gnt", 32'(bus.gnt), 32'h0);
        to_edge();
        check("idle_valid", 32'(bus.out_valid), 32'h0);
        check("idle_sel", 32'(bus.out_sel), 32'h3);
        check("idle_data", 32'(bus.out_data), 32'hA5);
        to_mid();

        // Fill from channel 0, then hold under backpressure
        bus.req = 5'b00001;
        #1;
        check("fill_gnt", 32'(bus.gnt), 32'h01);
        to_edge();
        to_mid();
        bus.req = 5'b00110;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp_gnt%0d", i), 32'(bus.gnt), 32'h0);
            to_edge();
            check($sformatf("bp_valid%0d", i), 32'(bus.out_valid), 32'h1);
            check($sformatf("bp_sel%0d", i), 32'(bus.out_sel), 32'h0);
            check($sformatf("bp_data%0d", i), 32'(bus.out_data), 32'h11);
            to_mid();
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_gnt", 32'(bus.gnt), 32'h02);
        to_edge();
        check("bp_release_sel", 32'(bus.out_sel), 32'h1);
        to_mid();
        #1;
        check("bp_next_gnt", 32'(bus.gnt), 32'h04);
        to_edge();
        check("bp_next_sel", 32'(bus.out_sel), 32'h2);
        check("bp_next_valid", 32'(bus.out_valid), 32'h1);
        to_mid();

        // Reset while full takes effect without a clock edge
        bus.req = 5'b11111;
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(bus.out_valid), 32'h0);
        check("midrst_sel", 32'(bus.out_sel), 32'h0);
        check("midrst_gnt", 32'(bus.gnt), 32'h0);
        to_edge();
        check("midrst_hold_valid", 32'(bus.out_valid), 32'h0);
        to_mid();
        rst = 1'b0;
        #1;
        check("midrst_first_gnt", 32'(bus.gnt), 32'h01);
        to_edge();
        check("midrst_first_sel", 32'(bus.out_sel), 32'h0);
        check("midrst_first_data", 32'(bus.out_data), 32'h11);
        to_mid();

`ifdef MUX5_ARB_LOCK_EN
        // last=0: channel 2 wins, lock holds it, release moves on to 4
        bus.req = 5'b10100;
        #1;
        check("lock_first_gnt", 32'(bus.gnt), 32'h04);
        to_edge();
        to_mid();
        bus.lock = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("lock_hold_gnt%0d", i), 32'(bus.gnt), 32'h04);
            to_edge();
            check($sformatf("lock_hold_sel%0d", i), 32'(bus.out_sel), 32'h2);
            to_mid();
        end
        bus.lock = 1'b0;
        #1;
        check("lock_drop_gnt", 32'(bus.gnt), 32'h10);
        to_edge();
        to_mid();
        // Lock without req[last] falls back to round robin (last=4, next is 0)
        bus.lock = 1'b1;
        bus.req = 5'b00011;
        #1;
        check("lock_fallback_gnt", 32'(bus.gnt), 32'h01);
        to_edge();
        to_mid();
        bus.lock = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
